// File: rtl/controlador_ascensor.sv
// Elevator scheduler for a 4-floor car: latches button requests and runs a SCAN
// policy through move, door-open and idle states, driving motor, door and displays.
module controlador_ascensor #(
  parameter int unsigned T_VIAJE  = 8,
  parameter int unsigned T_PUERTA = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] boton_pres,
  output logic [1:0] piso_actual,
  output logic       subiendo,
  output logic       bajando,
  output logic       puerta_abierta,
  output logic [9:0] pendientes,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    REPOSO       = 2'd0,
    MOVER_ARRIBA = 2'd1,
    MOVER_ABAJO  = 2'd2,
    PUERTA       = 2'd3
  } estado_t;

  localparam logic [15:0] CARGA_VIAJE  = 16'(T_VIAJE - 1);
  localparam logic [15:0] CARGA_PUERTA = 16'(T_PUERTA - 1);

  estado_t     st, st_d;
  logic [1:0]  piso, piso_d, piso_sig;
  logic [9:0]  pend, pend_d;
  logic        dir, dir_d;          // 1 = up
  logic [15:0] cnt_viaje, cnt_viaje_d;
  logic [15:0] cnt_puerta, cnt_puerta_d;
  logic [3:0]  hay;                 // per-floor request summary
  logic        boton_valido, boton_aqui;

  // Cabin, up-call and down-call bits belonging to a floor.
  function automatic logic [9:0] mascara_piso(input logic [1:0] f);
    case (f)
      2'd0:    return 10'b00_0001_0001;
      2'd1:    return 10'b00_0110_0010;
      2'd2:    return 10'b01_1000_0100;
      default: return 10'b10_0000_1000;
    endcase
  endfunction

  function automatic logic [1:0] piso_boton(input logic [3:0] b);
    case (b)
      4'd1, 4'd5:  return 2'd0;
      4'd2, 4'd6, 4'd7: return 2'd1;
      4'd3, 4'd8, 4'd9: return 2'd2;
      default:     return 2'd3;
    endcase
  endfunction

  function automatic logic arriba(input logic [3:0] h, input logic [1:0] p);
    case (p)
      2'd0:    return |h[3:1];
      2'd1:    return |h[3:2];
      2'd2:    return h[3];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic abajo(input logic [3:0] h, input logic [1:0] p);
    case (p)
      2'd0:    return 1'b0;
      2'd1:    return h[0];
      2'd2:    return |h[1:0];
      default: return |h[2:0];
    endcase
  endfunction

  always_comb begin
    hay[0] = |(pend & mascara_piso(2'd0));
    hay[1] = |(pend & mascara_piso(2'd1));
    hay[2] = |(pend & mascara_piso(2'd2));
    hay[3] = |(pend & mascara_piso(2'd3));
  end

  assign boton_valido = (boton_pres >= 4'd1) && (boton_pres <= 4'd10);
  assign boton_aqui   = boton_valido && (piso_boton(boton_pres) == piso);

  always_comb begin
    st_d         = st;
    piso_d       = piso;
    dir_d        = dir;
    cnt_viaje_d  = cnt_viaje;
    cnt_puerta_d = cnt_puerta;
    pend_d       = pend;
    piso_sig     = piso;

    // Set first, then clear, so a clear on the same bit wins.
    if (boton_valido && !(st == PUERTA && boton_aqui))
      pend_d[boton_pres - 4'd1] = 1'b1;
    if (st == PUERTA)
      pend_d = pend_d & ~mascara_piso(piso);

    case (st)
      REPOSO: begin
        if (hay[piso]) begin
          st_d         = PUERTA;
          cnt_puerta_d = CARGA_PUERTA;
        end else if (arriba(hay, piso) && (dir || !abajo(hay, piso))) begin
          st_d        = MOVER_ARRIBA;
          dir_d       = 1'b1;
          cnt_viaje_d = CARGA_VIAJE;
        end else if (abajo(hay, piso)) begin
          st_d        = MOVER_ABAJO;
          dir_d       = 1'b0;
          cnt_viaje_d = CARGA_VIAJE;
        end
      end
      MOVER_ARRIBA, MOVER_ABAJO: begin
        if (cnt_viaje != 16'd0) begin
          cnt_viaje_d = cnt_viaje - 16'd1;
        end else if ((st == MOVER_ARRIBA && piso == 2'd3) ||
                     (st == MOVER_ABAJO  && piso == 2'd0)) begin
          st_d = REPOSO;
        end else begin
          piso_sig = (st == MOVER_ARRIBA) ? piso + 2'd1 : piso - 2'd1;
          piso_d   = piso_sig;
          if (hay[piso_sig]) begin
            st_d         = PUERTA;
            cnt_puerta_d = CARGA_PUERTA;
          end else if (dir ? arriba(hay, piso_sig) : abajo(hay, piso_sig)) begin
            cnt_viaje_d = CARGA_VIAJE;
          end else begin
            st_d = REPOSO;
          end
        end
      end
      PUERTA: begin
        if (boton_aqui)
          cnt_puerta_d = CARGA_PUERTA;
        else if (cnt_puerta != 16'd0)
          cnt_puerta_d = cnt_puerta - 16'd1;
        else
          st_d = REPOSO;
      end
      default: st_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= REPOSO;
      piso       <= '0;
      pend       <= '0;
      dir        <= 1'b1;
      cnt_viaje  <= '0;
      cnt_puerta <= '0;
    end else begin
      st         <= st_d;
      piso       <= piso_d;
      pend       <= pend_d;
      dir        <= dir_d;
      cnt_viaje  <= cnt_viaje_d;
      cnt_puerta <= cnt_puerta_d;
    end
  end

  assign estado         = st;
  assign piso_actual    = piso;
  assign pendientes     = pend;
  assign subiendo       = (st == MOVER_ARRIBA);
  assign bajando        = (st == MOVER_ABAJO);
  assign puerta_abierta = (st == PUERTA);

endmodule

// File: tb/tb_controlador_ascensor.sv
// Bench for controlador_ascensor: vector table, scenario sequences and random
// stimulus compared against a floor-level behavioural model.
module tb_controlador_ascensor;

  localparam int TV = 8;
  localparam int TP = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] boton_pres = '0;
  logic [1:0] piso_actual;
  logic       subiendo, bajando, puerta_abierta;
  logic [9:0] pendientes;
  logic [1:0] estado;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  controlador_ascensor #(.T_VIAJE(TV), .T_PUERTA(TP)) dut (
    .clk(clk), .reset(reset), .boton_pres(boton_pres),
    .piso_actual(piso_actual), .subiendo(subiendo), .bajando(bajando),
    .puerta_abierta(puerta_abierta), .pendientes(pendientes), .estado(estado)
  );

  // Model: mode 0 idle, 1 up, 2 down, 3 door; dir +1/-1; pending as a bit set.
  int       m_modo, m_piso, m_dir, m_t;
  bit [9:0] m_pend;

  function automatic int piso_de(input int c);
    return (c <= 4) ? c - 1 : (c - 4) / 2;
  endfunction

  function automatic bit tiene(input int f);
    for (int k = 0; k < 10; k++)
      if (m_pend[k] && piso_de(k + 1) == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit hay_arriba(input int f);
    for (int g = f + 1; g <= 3; g++) if (tiene(g)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit hay_abajo(input int f);
    for (int g = 0; g < f; g++) if (tiene(g)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelo(input logic r, input logic [3:0] b);
    int bi;
    bit valido, apunta;
    bit [9:0] nxt;
    bi = int'(b);
    if (r) begin
      m_modo = 0; m_piso = 0; m_pend = '0; m_dir = 1; m_t = 0;
      return;
    end
    valido = (bi >= 1 && bi <= 10);
    apunta = valido && piso_de(bi) == m_piso;
    nxt = m_pend;
    if (valido && !(m_modo == 3 && apunta)) nxt[bi - 1] = 1'b1;
    if (m_modo == 3)
      for (int k = 0; k < 10; k++) if (piso_de(k + 1) == m_piso) nxt[k] = 1'b0;
    case (m_modo)
      0: begin
        if (tiene(m_piso)) begin m_modo = 3; m_t = TP - 1; end
        else if (hay_arriba(m_piso) && (m_dir == 1 || !hay_abajo(m_piso))) begin
          m_modo = 1; m_dir = 1; m_t = TV - 1;
        end else if (hay_abajo(m_piso)) begin
          m_modo = 2; m_dir = -1; m_t = TV - 1;
        end
      end
      1, 2: begin
        if (m_t > 0) m_t--;
        else begin
          m_piso += (m_modo == 1) ? 1 : -1;
          if (tiene(m_piso)) begin m_modo = 3; m_t = TP - 1; end
          else if (m_dir == 1 ? hay_arriba(m_piso) : hay_abajo(m_piso)) m_t = TV - 1;
          else m_modo = 0;
        end
      end
      default: begin
        if (apunta) m_t = TP - 1;
        else if (m_t > 0) m_t--;
        else m_modo = 0;
      end
    endcase
    m_pend = nxt;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic paso(input logic r, input logic [3:0] b);
    logic [16:0] esperado;
    reset = r;
    boton_pres = b;
    modelo(r, b);
    @(posedge clk);
    #1;
    esperado = {2'(m_modo), 2'(m_piso), m_modo == 1, m_modo == 2, m_modo == 3, m_pend};
    chk("modelo", 32'({estado, piso_actual, subiendo, bajando, puerta_abierta, pendientes}),
        32'(esperado));
  endtask

  task automatic chk_hw(input string name, input int est, input int piso, input int pend);
    chk({name, ".estado"}, 32'(estado), est);
    chk({name, ".piso"}, 32'(piso_actual), piso);
    chk({name, ".pend"}, 32'(pendientes), pend);
    chk({name, ".subiendo"}, 32'(subiendo), 32'(est == 1));
    chk({name, ".bajando"}, 32'(bajando), 32'(est == 2));
    chk({name, ".puerta"}, 32'(puerta_abierta), 32'(est == 3));
  endtask

  typedef struct {
    logic       r;
    logic [3:0] b;
    int         n;
    int         est;
    int         piso;
    int         pend;
  } vec_t;

  vec_t tabla[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // reset / idle / ignored codes
    tabla.push_back('{1'b1, 4'd0,  2, 0, 0, 'h000});
    tabla.push_back('{1'b0, 4'd0, 20, 0, 0, 'h000});
    tabla.push_back('{1'b0, 4'd11, 1, 0, 0, 'h000});
    tabla.push_back('{1'b0, 4'd15, 1, 0, 0, 'h000});
    // single trip 0 -> 2
    tabla.push_back('{1'b0, 4'd3, 1, 0, 0, 'h004});
    tabla.push_back('{1'b0, 4'd0, 1, 1, 0, 'h004});
    tabla.push_back('{1'b0, 4'd0, 7, 1, 0, 'h004});
    tabla.push_back('{1'b0, 4'd0, 1, 1, 1, 'h004});
    tabla.push_back('{1'b0, 4'd0, 7, 1, 1, 'h004});
    tabla.push_back('{1'b0, 4'd0, 1, 3, 2, 'h004});
    tabla.push_back('{1'b0, 4'd0, 1, 3, 2, 'h000});
    tabla.push_back('{1'b0, 4'd0, 4, 3, 2, 'h000});
    tabla.push_back('{1'b0, 4'd0, 1, 0, 2, 'h000});
    // door hold at floor 2
    tabla.push_back('{1'b0, 4'd3, 1, 0, 2, 'h004});
    tabla.push_back('{1'b0, 4'd0, 1, 3, 2, 'h004});
    tabla.push_back('{1'b0, 4'd0, 2, 3, 2, 'h000});
    tabla.push_back('{1'b0, 4'd3, 1, 3, 2, 'h000});
    tabla.push_back('{1'b0, 4'd0, 5, 3, 2, 'h000});
    tabla.push_back('{1'b0, 4'd0, 1, 0, 2, 'h000});

    for (int i = 0; i < tabla.size(); i++) begin
      repeat (tabla[i].n) paso(tabla[i].r, tabla[i].b);
      chk_hw($sformatf("vec%0d", i), tabla[i].est, tabla[i].piso, tabla[i].pend);
    end

    // intermediate stop at floor 1 on the way to floor 3
    paso(1'b1, 4'd0);
    paso(1'b0, 4'd4);       chk_hw("stop.press", 0, 0, 'h008);
    paso(1'b0, 4'd0);       chk_hw("stop.move", 1, 0, 'h008);
    repeat (3) paso(1'b0, 4'd0);
    paso(1'b0, 4'd6);       chk_hw("stop.b2", 1, 0, 'h028);
    repeat (4) paso(1'b0, 4'd0);
    chk_hw("stop.arrive1", 3, 1, 'h028);
    paso(1'b0, 4'd0);       chk_hw("stop.clear", 3, 1, 'h008);
    repeat (4) paso(1'b0, 4'd0);
    chk_hw("stop.dooropen", 3, 1, 'h008);
    paso(1'b0, 4'd0);       chk_hw("stop.idle", 0, 1, 'h008);
    paso(1'b0, 4'd0);       chk_hw("stop.resume", 1, 1, 'h008);
    repeat (8) paso(1'b0, 4'd0);
    chk_hw("stop.f2", 1, 2, 'h008);
    repeat (8) paso(1'b0, 4'd0);
    chk_hw("stop.f3", 3, 3, 'h008);

    // direction priority from floor 1 going up
    paso(1'b1, 4'd0);
    paso(1'b0, 4'd2);
    repeat (9) paso(1'b0, 4'd0);
    chk_hw("dir.at1", 3, 1, 'h002);
    repeat (6) paso(1'b0, 4'd0);
    chk_hw("dir.idle1", 0, 1, 'h000);
    paso(1'b0, 4'd4);       chk_hw("dir.p4", 0, 1, 'h008);
    paso(1'b0, 4'd1);       chk_hw("dir.p1", 1, 1, 'h009);
    repeat (16) paso(1'b0, 4'd0);
    chk_hw("dir.at3", 3, 3, 'h009);
    repeat (6) paso(1'b0, 4'd0);
    chk_hw("dir.idle3", 0, 3, 'h001);
    paso(1'b0, 4'd0);       chk_hw("dir.down", 2, 3, 'h001);
    repeat (24) paso(1'b0, 4'd0);
    chk_hw("dir.at0", 3, 0, 'h001);

    // reset mid-travel
    paso(1'b1, 4'd0);
    paso(1'b0, 4'd3);
    paso(1'b0, 4'd0);
    repeat (8) paso(1'b0, 4'd0);
    chk_hw("rst.pass1", 1, 1, 'h004);
    repeat (3) paso(1'b0, 4'd0);
    paso(1'b1, 4'd0);       chk_hw("rst.mid", 0, 0, 'h000);

    // random traffic against the model
    paso(1'b0, 4'd0);
    for (int i = 0; i < 4000; i++) begin
      logic       r;
      logic [3:0] b;
      r = ($urandom_range(0, 599) == 0);
      b = ($urandom_range(0, 9) < 6) ? 4'd0 : 4'($urandom_range(1, 15));
      paso(r, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
